// File: rtl/hmc_agent_pkg.sv
// Shared constants, types and header helpers for the HMC TX flit deframer.
package hmc_agent_pkg;

   localparam int FPW       = 4;
   localparam int FLIT_SIZE = 128;
   localparam int DWIDTH    = FPW * FLIT_SIZE;
   localparam int MAX_LNG   = 9;
   localparam int IDX_W     = $clog2(FPW);

   typedef logic [FLIT_SIZE-1:0] flit_t;
   typedef logic [DWIDTH-1:0]    word_t;

   typedef enum logic {HUNT, PKT} deframe_state_e;

   function automatic logic [3:0] get_lng(input flit_t f);
      return f[10:7];
   endfunction

   function automatic logic lng_legal(input logic [3:0] lng);
      return (lng != 4'd0) && (lng <= 4'(MAX_LNG));
   endfunction

endpackage

// File: rtl/hmc_tx_flit_deframer_if.sv
// Word-in / flit-out stream bundle; master is the link/consumer side, slave is the deframer.
interface hmc_tx_flit_deframer_if;
   import hmc_agent_pkg::*;

   word_t in_data;
   logic  in_valid;
   logic  in_ready;
   flit_t out_flit;
   logic  out_valid;
   logic  out_ready;
   logic  out_sop;
   logic  out_eop;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_flit, out_valid, out_sop, out_eop
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_flit, out_valid, out_sop, out_eop
   );

endinterface

// File: rtl/hmc_word_to_flit_slicer.sv
// One-word buffer that presents its flits one slot at a time, flit 0 first.
module hmc_word_to_flit_slicer
   import hmc_agent_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  word_t word_data,
   input  logic  word_valid,
   output logic  word_ready,
   output flit_t flit_data,
   output logic  flit_valid,
   input  logic  flit_ready
);

   word_t            word_q;
   logic             full_q;
   logic [IDX_W-1:0] idx_q;
   flit_t            slots [FPW];
   logic             last_slot;
   logic             retire;
   logic             load;

   always_comb begin
      for (int k = 0; k < FPW; k++) begin
         slots[k] = word_q[k*FLIT_SIZE +: FLIT_SIZE];
      end
   end

   assign last_slot  = (idx_q == IDX_W'(FPW-1));
   assign retire     = full_q & flit_ready;
   // Refill in the same cycle the final slot leaves, so words stream without a bubble.
   assign word_ready = !rst && (!full_q || (retire && last_slot));
   assign load       = word_valid & word_ready;
   assign flit_data  = slots[idx_q];
   assign flit_valid = full_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         full_q <= 1'b0;
         idx_q  <= '0;
      end else if (load) begin
         word_q <= word_data;
         full_q <= 1'b1;
         idx_q  <= '0;
      end else if (retire) begin
         if (last_slot) begin
            full_q <= 1'b0;
            idx_q  <= '0;
         end else begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/hmc_tx_flit_deframer.sv
// Re-frames link TX words into a flit stream with sop/eop from the header LNG field.
//   state | meaning
//   HUNT  | looking for a header; zero flits are dropped
//   PKT   | inside a packet; rem flits still to go, every slot is payload
module hmc_tx_flit_deframer
   import hmc_agent_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   hmc_tx_flit_deframer_if.slave bus,
   output logic                  lng_err,
   output logic [15:0]           pkt_cnt
);

   flit_t          slot;
   logic           slot_valid;
   logic           slot_ready;
   logic           word_ready;
   deframe_state_e state_q, state_d;
   logic [3:0]     rem_q, rem_d;
   logic [15:0]    cnt_d;
   logic           err_seen_q, err_seen_d;
   logic           valid_c, sop_c, eop_c, err_c;
   logic [3:0]     lng;

   hmc_word_to_flit_slicer u_slicer (
      .clk        (clk),
      .rst        (rst),
      .word_data  (bus.in_data),
      .word_valid (bus.in_valid),
      .word_ready (word_ready),
      .flit_data  (slot),
      .flit_valid (slot_valid),
      .flit_ready (slot_ready)
   );

   assign bus.in_ready  = word_ready;
   assign bus.out_valid = valid_c;
   assign bus.out_sop   = sop_c;
   assign bus.out_eop   = eop_c;
   assign bus.out_flit  = valid_c ? slot : '0;
   assign lng_err       = err_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HUNT;
         rem_q      <= '0;
         pkt_cnt    <= '0;
         err_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         pkt_cnt    <= cnt_d;
         err_seen_q <= err_seen_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      cnt_d      = pkt_cnt;
      err_seen_d = err_seen_q;
      valid_c    = 1'b0;
      sop_c      = 1'b0;
      eop_c      = 1'b0;
      err_c      = 1'b0;
      slot_ready = 1'b0;
      lng        = get_lng(slot);

      case (state_q)
         HUNT: begin
            if (slot_valid) begin
               if (slot == '0) begin
                  slot_ready = 1'b1;
               end else begin
                  valid_c    = 1'b1;
                  sop_c      = 1'b1;
                  slot_ready = bus.out_ready;
                  if (!lng_legal(lng)) begin
                     eop_c = 1'b1;
                     // err_seen_q keeps a stalled bad header from pulsing more than once.
                     err_c = !err_seen_q;
                  end else if (lng == 4'd1) begin
                     eop_c = 1'b1;
                  end else if (bus.out_ready) begin
                     rem_d   = lng - 4'd1;
                     state_d = PKT;
                  end
               end
            end
         end
         PKT: begin
            if (slot_valid) begin
               valid_c    = 1'b1;
               eop_c      = (rem_q == 4'd1);
               slot_ready = bus.out_ready;
               if (bus.out_ready) begin
                  rem_d = rem_q - 4'd1;
                  if (rem_q == 4'd1) state_d = HUNT;
               end
            end
         end
         default: state_d = HUNT;
      endcase

      if (valid_c && bus.out_ready) begin
         err_seen_d = 1'b0;
         if (eop_c) cnt_d = pkt_cnt + 16'd1;
      end else if (err_c) begin
         err_seen_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_hmc_tx_flit_deframer.sv
// Directed bench for the HMC TX flit deframer: framing, drops, stalls, length errors, reset.
module tb_hmc_tx_flit_deframer;
   import hmc_agent_pkg::*;

   typedef struct {
      flit_t f;
      logic  sop;
      logic  eop;
      int    cyc;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lng_err;
   logic [15:0] pkt_cnt;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          err_pulses = 0;
   obs_t        obs_q [$];

   hmc_tx_flit_deframer_if bus_if ();

   hmc_tx_flit_deframer dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if),
      .lng_err (lng_err),
      .pkt_cnt (pkt_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      obs_t o;
      if (!rst) begin
         if (bus_if.out_valid && bus_if.out_ready) begin
            o.f   = bus_if.out_flit;
            o.sop = bus_if.out_sop;
            o.eop = bus_if.out_eop;
            o.cyc = cyc;
            obs_q.push_back(o);
         end
         if (lng_err) err_pulses++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic flit_t hdr(input logic [3:0] lng, input logic [7:0] tag);
      flit_t f;
      f          = '0;
      f[127:120] = tag;
      f[10:7]    = lng;
      f[5:0]     = 6'h2A;
      return f;
   endfunction

   function automatic flit_t pay(input logic [7:0] tag, input logic [7:0] n);
      flit_t f;
      f          = '0;
      f[127:120] = tag;
      f[23:16]   = n;
      f[0]       = 1'b1;
      return f;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_words(input word_t ws [$]);
      for (int i = 0; i < ws.size(); i++) begin
         int n;
         n = 0;
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = ws[i];
         #1;
         while (bus_if.in_ready !== 1'b1 && n < 60) begin
            step;
            #1;
            n++;
         end
         if (n >= 60) begin
            errors++;
            $display("FAIL drive_timeout word %0d in_ready=%b required 1", i, bus_if.in_ready);
         end
         step;
      end
      bus_if.in_valid = 1'b0;
   endtask

   task automatic wait_obs(input int n);
      int k;
      k = 0;
      while (obs_q.size() < n && k < 100) begin
         step;
         k++;
      end
      if (obs_q.size() < n) begin
         errors++;
         $display("FAIL wait_obs got %0d flits required %0d", obs_q.size(), n);
      end
      repeat (6) step;
   endtask

   task automatic test_reset;
      rst              = 1'b1;
      bus_if.out_ready = 1'b1;
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = {flit_t'(0), flit_t'(0), flit_t'(0), hdr(4'd1, 8'hEE)};
      for (int k = 0; k < 3; k++) begin
         step;
         #1;
         checks++;
         if (bus_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready cycle %0d got %b required 0", k, bus_if.in_ready);
         end
         checks++;
         if (bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid cycle %0d got %b required 0", k, bus_if.out_valid);
         end
         checks++;
         if (pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_pkt_cnt cycle %0d got %0d required 0", k, pkt_cnt);
         end
      end
      step;
      rst             = 1'b0;
      bus_if.in_valid = 1'b0;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready got %b required 1", bus_if.in_ready);
      end
      checks++;
      if ({bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, lng_err} !== 4'b0000 ||
          bus_if.out_flit !== '0) begin
         errors++;
         $display("FAIL release_outputs got v%b s%b e%b err%b flit %h required all 0",
                  bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, lng_err, bus_if.out_flit);
      end
      step;
      #1;
      checks++;
      if (bus_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_load got out_valid %b required 0", bus_if.out_valid);
      end
   endtask

   task automatic test_single;
      flit_t h;
      h = hdr(4'd1, 8'h11);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = {flit_t'(0), flit_t'(0), flit_t'(0), h};
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_in_ready got %b required 1", bus_if.in_ready);
      end
      step;
      bus_if.in_valid = 1'b0;
      #1;
      checks++;
      if ({bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, lng_err} !== 4'b1110 ||
          bus_if.out_flit !== h) begin
         errors++;
         $display("FAIL single_hdr got v%b s%b e%b err%b flit %h required v1 s1 e1 err0 flit %h",
                  bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, lng_err, bus_if.out_flit, h);
      end
      for (int k = 1; k <= 3; k++) begin
         step;
         #1;
         checks++;
         if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== (k == 3)) begin
            errors++;
            $display("FAIL single_drop slot %0d got out_valid %b in_ready %b required 0 %b",
                     k, bus_if.out_valid, bus_if.in_ready, (k == 3));
         end
      end
      step;
      #1;
      checks++;
      if (pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL single_pkt_cnt got %0d required 1", pkt_cnt);
      end
   endtask

   task automatic test_span;
      word_t wq [$];
      flit_t ef [6];
      logic  es [6];
      logic  ee [6];
      obs_q.delete();
      ef[0] = hdr(4'd6, 8'h22);
      for (int i = 1; i < 6; i++) ef[i] = pay(8'h22, 8'(i));
      for (int i = 0; i < 6; i++) begin
         es[i] = (i == 0);
         ee[i] = (i == 5);
      end
      wq.push_back({ef[1], ef[0], flit_t'(0), flit_t'(0)});
      wq.push_back({ef[5], ef[4], ef[3], ef[2]});
      drive_words(wq);
      wait_obs(6);
      checks++;
      if (obs_q.size() != 6) begin
         errors++;
         $display("FAIL span_count got %0d required 6", obs_q.size());
      end
      for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
         checks++;
         if ({obs_q[i].f, obs_q[i].sop, obs_q[i].eop} !== {ef[i], es[i], ee[i]}) begin
            errors++;
            $display("FAIL span_flit %0d got %h s%b e%b required %h s%b e%b",
                     i, obs_q[i].f, obs_q[i].sop, obs_q[i].eop, ef[i], es[i], ee[i]);
         end
      end
      checks++;
      if (pkt_cnt !== 16'd2) begin
         errors++;
         $display("FAIL span_pkt_cnt got %0d required 2", pkt_cnt);
      end
   endtask

   task automatic test_back_to_back;
      word_t wq [$];
      flit_t ef [8];
      obs_q.delete();
      for (int p = 0; p < 2; p++) begin
         ef[p*4] = hdr(4'd4, 8'(8'h30 + p));
         for (int i = 1; i < 4; i++) ef[p*4+i] = pay(8'(8'h30 + p), 8'(i));
      end
      wq.push_back({ef[3], ef[2], ef[1], ef[0]});
      wq.push_back({ef[7], ef[6], ef[5], ef[4]});
      drive_words(wq);
      wait_obs(8);
      checks++;
      if (obs_q.size() != 8) begin
         errors++;
         $display("FAIL b2b_count got %0d required 8", obs_q.size());
      end
      for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
         checks++;
         if ({obs_q[i].f, obs_q[i].sop, obs_q[i].eop} !== {ef[i], (i % 4) == 0, (i % 4) == 3} ||
             obs_q[i].cyc - obs_q[0].cyc != i) begin
            errors++;
            $display("FAIL b2b_flit %0d got %h s%b e%b at +%0d required %h s%b e%b at +%0d",
                     i, obs_q[i].f, obs_q[i].sop, obs_q[i].eop, obs_q[i].cyc - obs_q[0].cyc,
                     ef[i], (i % 4) == 0, (i % 4) == 3, i);
         end
      end
      checks++;
      if (pkt_cnt !== 16'd4) begin
         errors++;
         $display("FAIL b2b_pkt_cnt got %0d required 4", pkt_cnt);
      end
   endtask

   task automatic test_backpressure;
      word_t wq [$];
      flit_t ef [8];
      flit_t snap_f;
      logic  snap_s, snap_e;
      int    err0;
      obs_q.delete();
      err0 = err_pulses;
      ef[0] = hdr(4'd8, 8'h44);
      for (int i = 1; i < 8; i++) ef[i] = pay(8'h44, 8'(i));
      wq.push_back({ef[3], ef[2], ef[1], ef[0]});
      wq.push_back({ef[7], ef[6], ef[5], ef[4]});
      fork
         drive_words(wq);
         begin
            int n;
            n = 0;
            while (obs_q.size() < 2 && n < 50) begin
               @(negedge clk);
               #1;
               n++;
            end
            step;
            bus_if.out_ready = 1'b0;
            #1;
            snap_f = bus_if.out_flit;
            snap_s = bus_if.out_sop;
            snap_e = bus_if.out_eop;
            checks++;
            if (bus_if.out_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_stall_valid got %b required 1", bus_if.out_valid);
            end
            for (int k = 0; k < 4; k++) begin
               step;
               #1;
               checks++;
               if ({bus_if.out_flit, bus_if.out_sop, bus_if.out_eop, bus_if.out_valid} !==
                   {snap_f, snap_s, snap_e, 1'b1} || bus_if.in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL bp_hold cycle %0d got %h s%b e%b v%b rdy%b required %h s%b e%b v1 rdy0",
                           k, bus_if.out_flit, bus_if.out_sop, bus_if.out_eop, bus_if.out_valid,
                           bus_if.in_ready, snap_f, snap_s, snap_e);
               end
            end
            step;
            bus_if.out_ready = 1'b1;
         end
      join
      wait_obs(8);
      checks++;
      if (obs_q.size() != 8) begin
         errors++;
         $display("FAIL bp_count got %0d required 8", obs_q.size());
      end
      for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
         checks++;
         if ({obs_q[i].f, obs_q[i].sop, obs_q[i].eop} !== {ef[i], i == 0, i == 7}) begin
            errors++;
            $display("FAIL bp_flit %0d got %h s%b e%b required %h s%b e%b",
                     i, obs_q[i].f, obs_q[i].sop, obs_q[i].eop, ef[i], i == 0, i == 7);
         end
      end
      checks++;
      if (pkt_cnt !== 16'd5 || err_pulses != err0) begin
         errors++;
         $display("FAIL bp_cnt got pkt_cnt %0d lng_err pulses %0d required 5 and 0",
                  pkt_cnt, err_pulses - err0);
      end
   endtask

   task automatic test_lng_err;
      word_t wq [$];
      flit_t h0, h12;
      int    err0;
      obs_q.delete();
      err0 = err_pulses;
      h0   = hdr(4'd0, 8'h55);
      h12  = hdr(4'd12, 8'h56);
      bus_if.out_ready = 1'b0;
      wq.push_back({flit_t'(0), flit_t'(0), h12, h0});
      drive_words(wq);
      repeat (4) step;
      bus_if.out_ready = 1'b1;
      wait_obs(2);
      checks++;
      if (obs_q.size() != 2) begin
         errors++;
         $display("FAIL lng_count got %0d required 2", obs_q.size());
      end
      if (obs_q.size() >= 2) begin
         checks++;
         if ({obs_q[0].f, obs_q[0].sop, obs_q[0].eop} !== {h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL lng0_flit got %h s%b e%b required %h s1 e1",
                     obs_q[0].f, obs_q[0].sop, obs_q[0].eop, h0);
         end
         checks++;
         if ({obs_q[1].f, obs_q[1].sop, obs_q[1].eop} !== {h12, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL lng12_flit got %h s%b e%b required %h s1 e1",
                     obs_q[1].f, obs_q[1].sop, obs_q[1].eop, h12);
         end
      end
      checks++;
      if (err_pulses - err0 != 2) begin
         errors++;
         $display("FAIL lng_err_pulses got %0d required 2", err_pulses - err0);
      end
      checks++;
      if (pkt_cnt !== 16'd7) begin
         errors++;
         $display("FAIL lng_pkt_cnt got %0d required 7", pkt_cnt);
      end
   endtask

   task automatic test_reset_mid;
      word_t wq [$];
      flit_t ef [4];
      logic  es [4];
      logic  ee [4];
      flit_t h4, p1, p2, p3, h2, pz;
      obs_q.delete();
      h4 = hdr(4'd4, 8'h66);
      p1 = pay(8'h66, 8'd1);
      p2 = pay(8'h66, 8'd2);
      p3 = pay(8'h66, 8'd3);
      h2 = hdr(4'd2, 8'h77);
      pz = pay(8'h77, 8'd1);
      ef[0] = h4; es[0] = 1'b1; ee[0] = 1'b0;
      ef[1] = p1; es[1] = 1'b0; ee[1] = 1'b0;
      ef[2] = h2; es[2] = 1'b1; ee[2] = 1'b0;
      ef[3] = pz; es[3] = 1'b0; ee[3] = 1'b1;
      bus_if.out_ready = 1'b1;
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = {p3, p2, p1, h4};
      step;
      bus_if.in_valid = 1'b0;
      step;
      step;
      rst              = 1'b1;
      bus_if.out_ready = 1'b0;
      step;
      rst              = 1'b0;
      bus_if.out_ready = 1'b1;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || pkt_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rmid_after_reset got rdy%b v%b cnt %0d required rdy1 v0 cnt 0",
                  bus_if.in_ready, bus_if.out_valid, pkt_cnt);
      end
      step;
      wq.push_back({flit_t'(0), flit_t'(0), pz, h2});
      drive_words(wq);
      wait_obs(4);
      checks++;
      if (obs_q.size() != 4) begin
         errors++;
         $display("FAIL rmid_count got %0d required 4", obs_q.size());
      end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         checks++;
         if ({obs_q[i].f, obs_q[i].sop, obs_q[i].eop} !== {ef[i], es[i], ee[i]}) begin
            errors++;
            $display("FAIL rmid_flit %0d got %h s%b e%b required %h s%b e%b",
                     i, obs_q[i].f, obs_q[i].sop, obs_q[i].eop, ef[i], es[i], ee[i]);
         end
      end
      checks++;
      if (pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL rmid_pkt_cnt got %0d required 1", pkt_cnt);
      end
   endtask

   initial begin
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.out_ready = 1'b1;
      test_reset;
      test_single;
      test_span;
      test_back_to_back;
      test_backpressure;
      test_lng_err;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
